// File: rtl/audio_codec_cfg_seq.sv
// audio_codec_cfg_seq: power-up register writer for a WM8731-class codec on its 2-wire
// control bus. Walks an 11-entry table, one 3-byte write per entry, with ACK check and retry.
module audio_codec_cfg_seq #(
    parameter int         CLK_DIV    = 125,
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         MAX_RETRY  = 3,
    parameter int         GAP_TICKS  = 8,
    parameter bit         AUTO_START = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       i2c_sdat_in,
    output logic       i2c_sclk,
    output logic       i2c_sdat_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] err_index
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_TICKS - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [3:0]    LAST_ENTRY  = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BYTE,
        S_ACK,
        S_STOP,
        S_GAP,
        S_FIN,
        S_ERR
    } state_t;

    // What the GAP state does once it expires.
    typedef enum logic [1:0] {
        OUT_OK,
        OUT_RETRY,
        OUT_FAIL
    } outcome_t;

    // Entry packed as {reg[6:0], data[8:0]}, so bits [15:8] are the second wire byte.
    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    table_entry = {7'h0F, 9'h000};
            4'd1:    table_entry = {7'h06, 9'h000};
            4'd2:    table_entry = {7'h00, 9'h017};
            4'd3:    table_entry = {7'h01, 9'h017};
            4'd4:    table_entry = {7'h02, 9'h079};
            4'd5:    table_entry = {7'h03, 9'h079};
            4'd6:    table_entry = {7'h04, 9'h012};
            4'd7:    table_entry = {7'h05, 9'h000};
            4'd8:    table_entry = {7'h07, 9'h042};
            4'd9:    table_entry = {7'h08, 9'h000};
            4'd10:   table_entry = {7'h09, 9'h001};
            default: table_entry = 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] wire_byte(input logic [3:0] idx, input logic [1:0] sel);
        logic [15:0] ent;
        ent = table_entry(idx);
        case (sel)
            2'd0:    wire_byte = {DEV_ADDR, 1'b0};
            2'd1:    wire_byte = ent[15:8];
            default: wire_byte = ent[7:0];
        endcase
    endfunction

    // Pad levels {sclk, sdat_oe} for a given state/quarter; b is the data bit being sent.
    function automatic logic [1:0] bus_levels(input state_t s, input logic [1:0] q, input logic b);
        case (s)
            S_START: begin
                case (q)
                    2'd0:    bus_levels = 2'b10;
                    2'd1:    bus_levels = 2'b11;
                    default: bus_levels = 2'b01;
                endcase
            end
            S_BYTE:  bus_levels = {q[1], ~b};
            S_ACK:   bus_levels = {q[1], 1'b0};
            S_STOP: begin
                case (q)
                    2'd0:    bus_levels = 2'b01;
                    2'd1:    bus_levels = 2'b11;
                    default: bus_levels = 2'b10;
                endcase
            end
            default: bus_levels = 2'b10;
        endcase
    endfunction

    state_t        state, state_d;
    outcome_t      outcome, outcome_d;
    logic [1:0]    phase, phase_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [1:0]    byte_sel, byte_sel_d;
    logic [3:0]    index, index_d;
    logic [RW-1:0] retry_cnt, retry_d;
    logic [GW-1:0] gap_cnt, gap_d;
    logic [DW-1:0] div_cnt;
    logic [7:0]    byte_val_d;
    logic [1:0]    levels_d;
    logic          sdat_meta, sdat_sync;
    logic          auto_pending;
    logic          tick;
    logic          launch;

    assign busy      = !(state inside {S_IDLE, S_FIN, S_ERR});
    assign done      = (state == S_FIN);
    assign error     = (state == S_ERR);
    assign err_index = error ? index : 4'd0;
    assign tick      = busy && (div_cnt == DIV_LAST);
    assign launch    = start || auto_pending;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt      <= '0;
            sdat_meta    <= 1'b1;
            sdat_sync    <= 1'b1;
            auto_pending <= AUTO_START;
        end else begin
            sdat_meta    <= i2c_sdat_in;
            sdat_sync    <= sdat_meta;
            auto_pending <= 1'b0;
            if (!busy || tick) div_cnt <= '0;
            else               div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            outcome     <= OUT_OK;
            phase       <= '0;
            bit_idx     <= 3'd7;
            byte_sel    <= '0;
            index       <= '0;
            retry_cnt   <= '0;
            gap_cnt     <= '0;
            i2c_sclk    <= 1'b1;
            i2c_sdat_oe <= 1'b0;
        end else begin
            state       <= state_d;
            outcome     <= outcome_d;
            phase       <= phase_d;
            bit_idx     <= bit_idx_d;
            byte_sel    <= byte_sel_d;
            index       <= index_d;
            retry_cnt   <= retry_d;
            gap_cnt     <= gap_d;
            {i2c_sclk, i2c_sdat_oe} <= levels_d;
        end
    end

    always_comb begin
        // NOTE: every variable takes its hold value first so no branch can leave one unassigned and infer a latch.
        state_d    = state;
        outcome_d  = outcome;
        phase_d    = phase;
        bit_idx_d  = bit_idx;
        byte_sel_d = byte_sel;
        index_d    = index;
        retry_d    = retry_cnt;
        gap_d      = gap_cnt;

        case (state)
            S_IDLE, S_FIN, S_ERR: begin
                if (launch) begin
                    state_d    = S_START;
                    outcome_d  = OUT_OK;
                    phase_d    = '0;
                    bit_idx_d  = 3'd7;
                    byte_sel_d = '0;
                    index_d    = '0;
                    retry_d    = '0;
                    gap_d      = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    phase_d = phase + 2'd1;
                    if (phase == 2'd3) begin
                        state_d    = S_BYTE;
                        byte_sel_d = '0;
                        bit_idx_d  = 3'd7;
                    end
                end
            end
            S_BYTE: begin
                if (tick) begin
                    phase_d = phase + 2'd1;
                    if (phase == 2'd3) begin
                        if (bit_idx == 3'd0) state_d = S_ACK;
                        else                 bit_idx_d = bit_idx - 3'd1;
                    end
                end
            end
            S_ACK: begin
                if (tick) begin
                    phase_d = phase + 2'd1;
                    if (phase == 2'd3) begin
                        if (sdat_sync) begin
                            state_d = S_STOP;
                            if (retry_cnt == RETRY_LIMIT) begin
                                outcome_d = OUT_FAIL;
                            end else begin
                                outcome_d = OUT_RETRY;
                                retry_d   = retry_cnt + RW'(1);
                            end
                        end else if (byte_sel == 2'd2) begin
                            state_d   = S_STOP;
                            outcome_d = OUT_OK;
                            retry_d   = '0;
                        end else begin
                            state_d    = S_BYTE;
                            byte_sel_d = byte_sel + 2'd1;
                            bit_idx_d  = 3'd7;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    phase_d = phase + 2'd1;
                    if (phase == 2'd3) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_d   = '0;
                        phase_d = '0;
                        case (outcome)
                            OUT_OK: begin
                                if (index == LAST_ENTRY) begin
                                    state_d = S_FIN;
                                end else begin
                                    state_d = S_START;
                                    index_d = index + 4'd1;
                                end
                            end
                            OUT_RETRY: state_d = S_START;
                            default:   state_d = S_ERR;
                        endcase
                    end else begin
                        gap_d = gap_cnt + GW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pads are registered from the next state so they move on the same edge as the FSM.
        byte_val_d = wire_byte(index_d, byte_sel_d);
        levels_d   = bus_levels(state_d, phase_d, byte_val_d[bit_idx_d]);
    end

endmodule

// File: tb/tb_audio_codec_cfg_seq.sv
// Bench for audio_codec_cfg_seq: a bus-level slave decodes every write and ACKs/NACKs by
// policy; decoded transactions are compared against a table-driven expected list.
module tb_audio_codec_cfg_seq;

    localparam int CLK_DIV   = 4;
    localparam int GAP_TICKS = 8;
    localparam int MAX_RETRY = 3;
    localparam int BIT_CLKS  = 4 * CLK_DIV;
    localparam int RUN_LIMIT = 12000;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       sclk, sdat_oe, busy, done, error;
    logic [3:0] err_index;
    logic       slave_pull = 1'b0;
    logic       sda;

    assign sda = ~(sdat_oe | slave_pull);

    audio_codec_cfg_seq #(
        .CLK_DIV   (CLK_DIV),
        .DEV_ADDR  (7'h1A),
        .MAX_RETRY (MAX_RETRY),
        .GAP_TICKS (GAP_TICKS),
        .AUTO_START(1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .i2c_sdat_in(sda),
        .i2c_sclk   (sclk),
        .i2c_sdat_oe(sdat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_index  (err_index)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Codec register table as documented: {reg, data}.
    logic [6:0] REG_T [11] = '{7'h0F, 7'h06, 7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h07, 7'h08, 7'h09};
    logic [8:0] DAT_T [11] = '{9'h000, 9'h000, 9'h017, 9'h017, 9'h079, 9'h079, 9'h012, 9'h000, 9'h042, 9'h000, 9'h001};

    // Transaction word: {b0, b1, b2, nbytes[3:0], 1'b0, ack_mask[2:0]}; unsent bytes are zero.
    logic [31:0] exp_q [$];
    logic [31:0] obs_q [$];
    logic        exp_err;
    logic [3:0]  exp_idx;

    int pol_entry = 0, pol_byte = 0, pol_count = 0;
    int sl_entry = 0, nacks_given = 0;

    function automatic logic [31:0] make_word(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input int nb, input logic [2:0] mask);
        logic [7:0] k1, k2;
        k1 = (nb > 1) ? b1 : 8'h00;
        k2 = (nb > 2) ? b2 : 8'h00;
        return {b0, k1, k2, 4'(nb), 1'b0, mask};
    endfunction

    task automatic build_expected(input int pe, input int pb, input int pc);
        logic [7:0] b1, b2;
        int n;
        exp_q.delete();
        exp_err = 1'b0;
        exp_idx = 4'd0;
        for (int e = 0; e < 11; e++) begin
            b1 = {REG_T[e], DAT_T[e][8]};
            b2 = DAT_T[e][7:0];
            n  = (e == pe) ? pc : 0;
            for (int a = 0; a < n && a <= MAX_RETRY; a++)
                exp_q.push_back(make_word(8'h34, b1, b2, pb + 1, 3'((1 << pb) - 1)));
            if (n > MAX_RETRY) begin
                exp_err = 1'b1;
                exp_idx = 4'(e);
                return;
            end
            exp_q.push_back(make_word(8'h34, b1, b2, 3, 3'b111));
        end
    endtask

    // Bus monitor and slave, sampled on the falling clock edge.
    logic        p_scl = 1'b1, p_sda = 1'b1;
    logic        in_xfer = 1'b0, rise_pending = 1'b0, rise_val = 1'b1;
    logic        have_prev = 1'b0, have_stop = 1'b0, nack;
    int          bitn = 0, nbytes = 0;
    logic [7:0]  cur_byte = 8'h00;
    logic [7:0]  xb [3];
    logic [2:0]  ack_mask = 3'b000;
    int unsigned last_rise = 0, cur_per = 0, stop_cyc = 0;

    always @(negedge clk) begin
        if (reset) begin
            in_xfer      = 1'b0;
            rise_pending = 1'b0;
            have_prev    = 1'b0;
            have_stop    = 1'b0;
            bitn         = 0;
            nbytes       = 0;
            slave_pull   = 1'b0;
        end else begin
            if (sclk && p_scl && p_sda && !sda) begin
                check("start_outside_xfer", in_xfer, 1'b0);
                if (have_stop)
                    check("gap_min", (cyc - stop_cyc) >= GAP_TICKS * CLK_DIV, 1'b1);
                in_xfer      = 1'b1;
                bitn         = 0;
                nbytes       = 0;
                xb           = '{8'h00, 8'h00, 8'h00};
                ack_mask     = 3'b000;
                have_prev    = 1'b0;
                rise_pending = 1'b0;
            end else if (sclk && p_scl && !p_sda && sda) begin
                check("stop_in_xfer", in_xfer, 1'b1);
                check("stop_on_byte_boundary", bitn, 0);
                obs_q.push_back({xb[0], xb[1], xb[2], 4'(nbytes), 1'b0, ack_mask});
                if (nbytes == 3 && ack_mask == 3'b111) sl_entry++;
                in_xfer      = 1'b0;
                rise_pending = 1'b0;
                have_stop    = 1'b1;
                stop_cyc     = cyc;
            end
            if (sclk && !p_scl) begin
                cur_per      = have_prev ? (cyc - last_rise) : 0;
                last_rise    = cyc;
                have_prev    = 1'b1;
                rise_val     = sda;
                rise_pending = 1'b1;
            end
            if (!sclk && p_scl && rise_pending) begin
                rise_pending = 1'b0;
                if (cur_per != 0) check("scl_period", cur_per, BIT_CLKS);
                if (bitn < 8) begin
                    cur_byte = {cur_byte[6:0], rise_val};
                    bitn++;
                    if (bitn == 8) begin
                        if (nbytes < 3) xb[nbytes] = cur_byte;
                        nack = in_xfer && (sl_entry == pol_entry) && (nbytes == pol_byte)
                               && (nacks_given < pol_count);
                        if (nack) nacks_given++;
                        slave_pull = !nack;
                    end
                end else begin
                    if (nbytes < 3) ack_mask[nbytes] = !rise_val;
                    nbytes++;
                    bitn       = 0;
                    slave_pull = 1'b0;
                end
            end
        end
        p_scl = sclk;
        p_sda = ~(sdat_oe | slave_pull);
    end

    task automatic setup_run(input int pe, input int pb, input int pc);
        pol_entry   = pe;
        pol_byte    = pb;
        pol_count   = pc;
        sl_entry    = 0;
        nacks_given = 0;
        obs_q.delete();
        build_expected(pe, pb, pc);
    endtask

    task automatic launch();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_on_accept", busy, 1'b1);
        check("done_cleared", done, 1'b0);
        check("error_cleared", error, 1'b0);
    endtask

    task automatic finish_run(input bit poke);
        int waitc;
        if (poke) begin
            waitc = $urandom_range(50, 3000);
            for (int i = 0; i < waitc && busy; i++) begin
                @(posedge clk);
                #1;
            end
            if (busy) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        for (int i = 0; i < RUN_LIMIT && busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("run_terminates", busy, 1'b0);
        check("done", done, !exp_err);
        check("error", error, exp_err);
        check("err_index", err_index, exp_err ? exp_idx : 4'd0);
        check("sclk_idle", sclk, 1'b1);
        check("sdat_released", sdat_oe, 1'b0);
        check("n_xfers", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check($sformatf("xfer%0d", i), obs_q[i], exp_q[i]);
    endtask

    initial begin
        int found;
        int pe, pb, pc;

        // Reset values, then auto-start with an always-ACK slave.
        setup_run(0, 0, 0);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", sclk, 1'b1);
        check("rst_sdat_oe", sdat_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_err_index", err_index, 4'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("busy_auto_start", busy, 1'b1);
        finish_run(1'b0);

        // Entry 4 address byte NACKed twice, then accepted; start poked mid-run.
        setup_run(4, 0, 2);
        launch();
        finish_run(1'b1);

        // Entry 2 never accepted: retries exhausted.
        setup_run(2, $urandom_range(0, 2), 9);
        launch();
        finish_run(1'b1);

        // Restart after error runs the whole table again.
        setup_run(0, 0, 0);
        launch();
        finish_run(1'b1);

        // Reset asserted mid-byte of entry 6.
        setup_run(0, 0, 0);
        launch();
        found = 0;
        for (int i = 0; i < RUN_LIMIT; i++) begin
            @(negedge clk);
            if (obs_q.size() == 6 && in_xfer && nbytes == 1 && bitn == 4) begin
                found = 1;
                break;
            end
        end
        check("reached_entry6", found, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("async_rst_sclk", sclk, 1'b1);
        check("async_rst_sdat_oe", sdat_oe, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        setup_run(0, 0, 0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("busy_restart", busy, 1'b1);
        finish_run(1'b0);

        // Randomised NACK policies.
        for (int r = 0; r < 4; r++) begin
            pe = $urandom_range(0, 10);
            pb = $urandom_range(0, 2);
            pc = $urandom_range(0, 5);
            setup_run(pe, pb, pc);
            launch();
            finish_run(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end

endmodule
